arm_imm_encoder: RTL

ARM_IMM_ENCODER -- requirements
Module: arm_imm_encoder

---
 rtl/arm_imm_encoder.sv | 102 ++++++++++
 1 files changed

// File: rtl/arm_imm_encoder.sv
// ARM immediate encoder: finds the data-processing rotated-immediate form
// (one rotation per cycle) or checks a 12-bit signed memory offset.
module arm_imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        is_mem,
  output logic        busy,
  output logic        done,
  output logic        encodable,
  output logic [11:0] shift_operand
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  r;
  logic [31:0] value_q;
  logic        is_mem_q;

  logic [5:0]  rot_amt;
  logic [31:0] cand;
  logic        dp_hit;
  logic        dp_last;
  logic        mem_fits;

  // Candidate for the current rotation; a left-rotate by 2r undoes the
  // right-rotate the decoder applies, so the hit leaves imm8 in cand[7:0].
  always_comb begin
    rot_amt  = {1'b0, r, 1'b0};
    cand     = (value_q << rot_amt) | (value_q >> (6'd32 - rot_amt));
    dp_hit   = (cand[31:8] == 24'd0);
    dp_last  = (r == 4'd15);
    mem_fits = (&value_q[31:11]) | ~(|value_q[31:11]);
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEARCH;
      SEARCH:  if (is_mem_q || dp_hit || dp_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // NOTE: value_q and is_mem_q are only read after being loaded on an accepted
  // start, so they carry no reset; everything observable is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r             <= 4'd0;
      encodable     <= 1'b0;
      shift_operand <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            value_q  <= value;
            is_mem_q <= is_mem;
            r        <= 4'd0;
          end
        end
        SEARCH: begin
          if (is_mem_q) begin
            encodable     <= mem_fits;
            shift_operand <= mem_fits ? value_q[11:0] : 12'h000;
          end else if (dp_hit) begin
            encodable     <= 1'b1;
            shift_operand <= {r, cand[7:0]};
          end else if (dp_last) begin
            encodable     <= 1'b0;
            shift_operand <= 12'h000;
          end else begin
            r <= r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
